// File: rtl/sram_arbiter.sv
// IFU/LSU round-robin arbiter and fixed-latency sequencer for the SRAM bridge.
// Ports: clk_i/rst_i; ifu_* fetch req/resp; lsu_* load/store req/resp;
// mem_* single-ported bridge strobe, address, write data/mask, read data;
// busy_o is high whenever the sequencer is not idle.
module sram_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_resp_valid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_wen_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_resp_valid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_e      state_q;
  logic        last_lsu_q;
  logic        own_lsu_q;
  logic        wen_q;
  logic [3:0]  cnt_q;
  logic        mem_valid_q;
  logic        mem_wen_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wmask_q;
  logic        ifu_resp_q;
  logic        lsu_resp_q;
  logic [31:0] ifu_rdata_q;
  logic [31:0] lsu_rdata_q;

  logic idle;
  logic pick_lsu;

  // LSU wins when alone, or on a tie when the IFU was granted last.
  always_comb begin
    idle     = (state_q == S_IDLE) && !rst_i;
    pick_lsu = lsu_req_valid_i &&
               (!ifu_req_valid_i || !last_lsu_q);
    lsu_req_ready_o = idle && pick_lsu;
    ifu_req_ready_o = idle && ifu_req_valid_i && !pick_lsu;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      last_lsu_q  <= 1'b0;
      own_lsu_q   <= 1'b0;
      wen_q       <= 1'b0;
      cnt_q       <= 4'd0;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      ifu_rdata_q <= 32'd0;
      lsu_rdata_q <= 32'd0;
    end else begin
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 1'b0;
      ifu_resp_q  <= 1'b0;
      lsu_resp_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (lsu_req_ready_o) begin
            own_lsu_q   <= 1'b1;
            last_lsu_q  <= 1'b1;
            wen_q       <= lsu_wen_i;
            mem_valid_q <= 1'b1;
            mem_wen_q   <= lsu_wen_i;
            mem_addr_q  <= lsu_addr_i;
            mem_wdata_q <= lsu_wdata_i;
            mem_wmask_q <= lsu_wmask_i;
            state_q     <= S_ISSUE;
          end else if (ifu_req_ready_o) begin
            own_lsu_q   <= 1'b0;
            last_lsu_q  <= 1'b0;
            wen_q       <= 1'b0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= ifu_addr_i & ~32'h3;
            mem_wdata_q <= 32'd0;
            mem_wmask_q <= 4'd0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= LAT4;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (own_lsu_q) begin
              lsu_rdata_q <= wen_q ? 32'd0 : mem_rdata_i;
              lsu_resp_q  <= 1'b1;
            end else begin
              ifu_rdata_q <= mem_rdata_i;
              ifu_resp_q  <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_valid_o      = mem_valid_q;
  assign mem_wen_o        = mem_wen_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign mem_wmask_o      = mem_wmask_q;
  assign ifu_resp_valid_o = ifu_resp_q;
  assign lsu_resp_valid_o = lsu_resp_q;
  assign ifu_rdata_o      = ifu_rdata_q;
  assign lsu_rdata_o      = lsu_rdata_q;
  assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: random IFU/LSU traffic against a
// transaction-level model, plus a MEM_LAT=3 instance for latency checks.
module tb_sram_arbiter;

  localparam int LAT  = 1;
  localparam int LAT2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_tab [0:4095];
  logic [31:0] mem_rdata;
  assign mem_rdata = rd_tab[cyc[11:0]];

  logic        ifu_v, ifu_rdy, ifu_rv;
  logic [31:0] ifu_a, ifu_rd;
  logic        lsu_v, lsu_rdy, lsu_we, lsu_rv;
  logic [31:0] lsu_a, lsu_wd, lsu_rd;
  logic [3:0]  lsu_wm;
  logic        m_v, m_we, busy;
  logic [31:0] m_a, m_wd;
  logic [3:0]  m_wm;

  sram_arbiter #(.MEM_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(ifu_v), .ifu_req_ready_o(ifu_rdy),
    .ifu_addr_i(ifu_a), .ifu_resp_valid_o(ifu_rv),
    .ifu_rdata_o(ifu_rd),
    .lsu_req_valid_i(lsu_v), .lsu_req_ready_o(lsu_rdy),
    .lsu_addr_i(lsu_a), .lsu_wen_i(lsu_we),
    .lsu_wdata_i(lsu_wd), .lsu_wmask_i(lsu_wm),
    .lsu_resp_valid_o(lsu_rv), .lsu_rdata_o(lsu_rd),
    .mem_valid_o(m_v), .mem_addr_o(m_a), .mem_wen_o(m_we),
    .mem_wdata_o(m_wd), .mem_wmask_o(m_wm),
    .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  logic        i2_v, i2_rdy, i2_rv, l2_rdy, l2_rv;
  logic [31:0] i2_a, i2_rd, l2_rd;
  logic        m2_v, m2_we, busy2;
  logic [31:0] m2_a, m2_wd;
  logic [3:0]  m2_wm;

  sram_arbiter #(.MEM_LAT(LAT2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .ifu_req_valid_i(i2_v), .ifu_req_ready_o(i2_rdy),
    .ifu_addr_i(i2_a), .ifu_resp_valid_o(i2_rv),
    .ifu_rdata_o(i2_rd),
    .lsu_req_valid_i(1'b0), .lsu_req_ready_o(l2_rdy),
    .lsu_addr_i(32'd0), .lsu_wen_i(1'b0),
    .lsu_wdata_i(32'd0), .lsu_wmask_i(4'd0),
    .lsu_resp_valid_o(l2_rv), .lsu_rdata_o(l2_rd),
    .mem_valid_o(m2_v), .mem_addr_o(m2_a), .mem_wen_o(m2_we),
    .mem_wdata_o(m2_wd), .mem_wmask_o(m2_wm),
    .mem_rdata_i(mem_rdata), .busy_o(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic        is_lsu;
    logic [31:0] rdata;
  } resp_exp_t;

  mem_exp_t  mq[$];
  resp_exp_t rq[$];

  // Transaction-level model: a grant occupies the bridge for LAT+3 cycles.
  int        free_cyc = 0;
  logic      last_lsu = 1'b0;
  logic      gi, gl;
  logic      ifu_hs = 1'b0, lsu_hs = 1'b0;
  mem_exp_t  pm;
  resp_exp_t pr;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem", {m_v, m_we, m_wm, m_a}, '0);
      chk("rst_wdata", m_wd, '0);
      chk("rst_rdata", {ifu_rd, lsu_rd}, '0);
      chk("rst_ctl", {ifu_rv, lsu_rv, ifu_rdy, lsu_rdy, busy}, '0);
      mq.delete();
      rq.delete();
      free_cyc = 0;
      last_lsu = 1'b0;
      ifu_hs   = 1'b0;
      lsu_hs   = 1'b0;
    end else begin
      gi = 1'b0;
      gl = 1'b0;
      if (cyc >= free_cyc) begin
        if (ifu_v && lsu_v) gl = !last_lsu;
        else                gl = lsu_v;
        gi = ifu_v && !gl;
      end
      chk("ready", {ifu_rdy, lsu_rdy}, {gi, gl});
      chk("busy", busy, cyc < free_cyc);
      ifu_hs = ifu_v && ifu_rdy;
      lsu_hs = lsu_v && lsu_rdy;
      if (gi || gl) begin
        pm.cyc    = cyc + 1;
        pm.is_lsu = gl;
        pm.addr   = gl ? lsu_a : {ifu_a[31:2], 2'b00};
        pm.wen    = gl && lsu_we;
        pm.wdata  = lsu_wd;
        pm.wmask  = gl ? lsu_wm : 4'd0;
        mq.push_back(pm);
        pr.cyc    = cyc + LAT + 2;
        pr.is_lsu = gl;
        pr.rdata  = (gl && lsu_we) ? 32'd0 :
                    rd_tab[12'(cyc + LAT + 1)];
        rq.push_back(pr);
        last_lsu  = gl;
        free_cyc  = cyc + LAT + 3;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  logic [31:0] h_addr = '0, h_ifu = '0, h_lsu = '0;
  logic [3:0]  h_wm = '0;
  mem_exp_t    me;
  resp_exp_t   re;

  always @(negedge clk) begin
    if (rst) begin
      h_addr = '0;
      h_wm   = '0;
      h_ifu  = '0;
      h_lsu  = '0;
    end else begin
      if (m_v) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected", 1'b1, 1'b0);
        end else begin
          me = mq.pop_front();
          chk("mem_cyc", cyc, me.cyc);
          chk("mem_addr", m_a, me.addr);
          chk("mem_wen", m_we, me.wen);
          chk("mem_wmask", m_wm, me.wmask);
          if (me.is_lsu) chk("mem_wdata", m_wd, me.wdata);
          h_addr = me.addr;
          h_wm   = me.wmask;
        end
      end else begin
        chk("mem_wen_idle", m_we, 1'b0);
        chk("mem_hold", {m_a, m_wm}, {h_addr, h_wm});
        if (mq.size() != 0 && mq[0].cyc <= cyc) begin
          chk("mem_missing", 1'b0, 1'b1);
          void'(mq.pop_front());
        end
      end
      if (ifu_rv || lsu_rv) begin
        chk("resp_both", ifu_rv && lsu_rv, 1'b0);
        if (rq.size() == 0) begin
          chk("resp_unexpected", 1'b1, 1'b0);
        end else begin
          re = rq.pop_front();
          chk("resp_cyc", cyc, re.cyc);
          chk("resp_owner", lsu_rv, re.is_lsu);
          if (re.is_lsu) h_lsu = re.rdata;
          else           h_ifu = re.rdata;
        end
      end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
        chk("resp_missing", 1'b0, 1'b1);
        void'(rq.pop_front());
      end
      chk("ifu_rdata", ifu_rd, h_ifu);
      chk("lsu_rdata", lsu_rd, h_lsu);
    end
  end

  int p_raise = 100;
  int p_drop  = 0;

  task automatic run_auto(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (ifu_hs) ifu_v = 1'b0;
      if (!ifu_v) begin
        if ($urandom_range(99) < p_raise) begin
          ifu_v = 1'b1;
          ifu_a = $urandom;
        end
      end else if ($urandom_range(99) < p_drop) begin
        ifu_v = 1'b0;
      end
      if (lsu_hs) lsu_v = 1'b0;
      if (!lsu_v) begin
        if ($urandom_range(99) < p_raise) begin
          lsu_v  = 1'b1;
          lsu_a  = $urandom;
          lsu_we = 1'($urandom);
          lsu_wd = $urandom;
          lsu_wm = 4'($urandom);
        end
      end else if ($urandom_range(99) < p_drop) begin
        lsu_v = 1'b0;
      end
    end
  endtask

  task automatic issue_ifu(input logic [31:0] a,
                           input logic [31:0] d);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    ifu_v = 1'b1;
    ifu_a = a;
    rd_tab[12'(cyc + LAT + 1)] = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifu_rdy) begin
        got = 1'b1;
        break;
      end
    end
    chk("ifu_accept", got, 1'b1);
    @(posedge clk); #1;
    ifu_v = 1'b0;
  endtask

  task automatic issue_lsu(input logic [31:0] a, input logic we,
                           input logic [31:0] wd,
                           input logic [3:0] wm);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    lsu_v  = 1'b1;
    lsu_a  = a;
    lsu_we = we;
    lsu_wd = wd;
    lsu_wm = wm;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lsu_rdy) begin
        got = 1'b1;
        break;
      end
    end
    chk("lsu_accept", got, 1'b1);
    @(posedge clk); #1;
    lsu_v = 1'b0;
  endtask

  int          t0;
  logic        got3;
  logic [31:0] a3;

  initial begin
    for (int i = 0; i < 4096; i++) rd_tab[i] = $urandom;
    ifu_v = 1'b0; ifu_a = '0;
    lsu_v = 1'b0; lsu_a = '0; lsu_we = 1'b0;
    lsu_wd = '0; lsu_wm = '0;
    i2_v = 1'b0; i2_a = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue_ifu(32'h8000_0004, 32'h0010_0093);
    repeat (5) @(posedge clk);
    issue_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    repeat (5) @(posedge clk);

    // Tie in the first cycle after reset, then both held valid.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ifu_v = 1'b1; ifu_a = $urandom;
    lsu_v = 1'b1; lsu_a = $urandom; lsu_we = 1'b0;
    lsu_wd = $urandom; lsu_wm = 4'($urandom);
    p_raise = 100; p_drop = 0;
    run_auto(24);

    p_raise = 40; p_drop = 10;
    run_auto(400);
    @(posedge clk); #1;
    ifu_v = 1'b0;
    lsu_v = 1'b0;
    repeat (8) @(posedge clk);

    // Reset during WAIT of an LSU load drops it; a tie afterwards
    // must go to the LSU again.
    issue_lsu($urandom, 1'b0, $urandom, 4'hF);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    ifu_v = 1'b1; ifu_a = $urandom;
    lsu_v = 1'b1; lsu_a = $urandom; lsu_we = 1'b0;
    lsu_wd = $urandom; lsu_wm = 4'($urandom);
    p_raise = 0; p_drop = 0;
    run_auto(12);
    repeat (4) @(posedge clk);

    // MEM_LAT=3 instance: response exactly 5 cycles after handshake.
    @(posedge clk); #1;
    a3 = $urandom & ~32'h3;
    i2_v = 1'b1;
    i2_a = a3;
    t0 = cyc;
    @(negedge clk);
    chk("l3_ready", i2_rdy, 1'b1);
    @(posedge clk); #1;
    i2_v = 1'b0;
    @(negedge clk);
    chk("l3_mem_valid", {m2_v, m2_we}, 2'b10);
    chk("l3_mem_addr", m2_a, a3);
    got3 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i2_rv) begin
        got3 = 1'b1;
        break;
      end
    end
    chk("l3_resp_seen", got3, 1'b1);
    if (got3) begin
      chk("l3_resp_cyc", cyc, t0 + LAT2 + 2);
      chk("l3_rdata", i2_rd, rd_tab[12'(t0 + LAT2 + 1)]);
    end
    chk("l3_lsu_quiet", {l2_rv, l2_rdy}, 2'b00);

    repeat (6) @(posedge clk);
    chk("queues_drained", mq.size() + rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

endmodule
